stream_master: RTL



---
 rtl/stream_pkg.sv | 19 +
 rtl/stream_cycle_timer.sv | 28 ++
 rtl/stream_master.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared types and constants for the LED stream master and its stages.
package stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;

  localparam int STREAM_STEP_CYCLES = 50000000;
  localparam int STREAM_LEDS        = 8;
  localparam logic [STREAM_LEDS-1:0] LED_OFF = 8'b0;

  // Wide enough for either the ack window or a 0.5 s gap at 100 MHz.
  localparam int TIMER_W = 26;

endpackage

// File: rtl/stream_cycle_timer.sv
// Loadable down-counter shared by the ack window and the inter-stage gap.
// zero flags the terminal cycle: the decrement under way lands on 0 (or it already sits there).
module stream_cycle_timer
  import stream_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  input  logic               en,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count <= TIMER_W'(1));

endmodule

// File: rtl/stream_master.sv
// Round-robin start-token sequencer for a chain of LED sweep stages.
// Define STREAM_PINGPONG_EN for up/down ordering instead of wrap-around.
module stream_master
  import stream_pkg::*;
#(
  parameter int N_STAGES    = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int GAP_CYCLES  = STREAM_STEP_CYCLES,
  parameter int IDX_W       = $clog2(N_STAGES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                clear_fault,
  input  logic [N_STAGES-1:0] stage_idle,
  output logic [N_STAGES-1:0] stage_start,
  output logic [IDX_W-1:0]    active_idx,
  output logic                busy,
  output logic                fault,
  output logic [7:0]          sweep_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);

  state_t             state;
  logic               tmr_load;
  logic               tmr_en;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_zero;
  logic               idle_sel;
  logic               all_idle;

`ifdef STREAM_PINGPONG_EN
  localparam logic [IDX_W-1:0] TURN_IDX = IDX_W'(N_STAGES - 2);
  logic dir_up;
`endif

  assign idle_sel = stage_idle[active_idx];
  assign all_idle = &stage_idle;

  always_comb begin
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_value = TIMER_W'(GAP_CYCLES);
    case (state)
      ST_ARM: begin
        tmr_load  = 1'b1;
        tmr_value = TIMER_W'(ACK_TIMEOUT);
      end
      ST_WAIT_BUSY: begin
        if (idle_sel && tmr_zero) begin
          tmr_load = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_WAIT_DONE: tmr_load = idle_sel;
      ST_GAP:       tmr_en   = 1'b1;
      default: ;
    endcase
  end

  stream_cycle_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .en    (tmr_en),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      stage_start <= '0;
      active_idx  <= '0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      sweep_count <= '0;
`ifdef STREAM_PINGPONG_EN
      dir_up      <= 1'b1;
`endif
    end else begin
      stage_start <= '0;
      if (clear_fault) begin
        fault <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (run && all_idle) begin
            state <= ST_ARM;
            busy  <= 1'b1;
          end
        end
        ST_ARM: begin
          stage_start <= N_STAGES'(1) << active_idx;
          state       <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!idle_sel) begin
            state <= ST_WAIT_DONE;
          end else if (tmr_zero) begin
            // Later than the clear so a simultaneous clear_fault cannot hide a new miss.
            fault <= 1'b1;
            state <= ST_GAP;
          end
        end
        ST_WAIT_DONE: begin
          if (idle_sel) begin
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_zero) begin
`ifdef STREAM_PINGPONG_EN
            if (dir_up) begin
              active_idx <= active_idx + 1'b1;
              if (active_idx == TURN_IDX) begin
                dir_up <= 1'b0;
              end
            end else begin
              active_idx <= active_idx - 1'b1;
              if (active_idx == IDX_W'(1)) begin
                dir_up      <= 1'b1;
                sweep_count <= sweep_count + 1'b1;
              end
            end
`else
            if (active_idx == LAST_IDX) begin
              active_idx  <= '0;
              sweep_count <= sweep_count + 1'b1;
            end else begin
              active_idx <= active_idx + 1'b1;
            end
`endif
            if (run && all_idle) begin
              state <= ST_ARM;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
